// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I instruction types, opcodes and immediate range helper
package rv32i_pkg;

  typedef enum logic [2:0] {
    INST_ERROR = 3'd0,
    INST_R     = 3'd1,
    INST_I     = 3'd2,
    INST_S     = 3'd3,
    INST_B     = 3'd4,
    INST_U     = 3'd5,
    INST_J     = 3'd6
  } inst_type_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // True when v is representable as a two's-complement number of 'bits' bits.
  function automatic logic sign_fits(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = $unsigned($signed(v) >>> (bits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with clock enable, no full-queue bypass
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full queue is dropped even when a pop frees a slot this cycle.
  assign do_push = push_i & clk_en & ~full_o;
  assign do_pop  = pop_i & clk_en & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/encode.sv
// rtl/encode.sv - RV32I field-bundle encoder with legality checks and output queue
module encode
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [2:0]             i_type,
  input  logic [6:0]             i_opcode,
  input  logic [6:0]             i_funct7,
  input  logic [2:0]             i_funct3,
  input  logic [4:0]             i_rs1,
  input  logic [4:0]             i_rs2,
  input  logic [4:0]             i_rd,
  input  logic [31:0]            i_imm,
  output logic [31:0]            o_instruction,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_error,
  output logic [$clog2(DEPTH):0] o_count
);

  logic [31:0] word;
  logic        legal;
  logic        accept, push, pop;
  logic        full, empty;
  logic        error_q, error_d;

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (i_type)
      INST_R: begin
        word  = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        legal = (i_opcode == OPC_OP);
      end
      INST_I: begin
        word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        legal = (i_opcode inside {OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM})
                && sign_fits(i_imm, 12);
      end
      INST_S: begin
        word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        legal = (i_opcode == OPC_STORE) && sign_fits(i_imm, 12);
      end
      INST_B: begin
        word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_opcode};
        legal = (i_opcode == OPC_BRANCH) && sign_fits(i_imm, 13) && !i_imm[0];
      end
      INST_U: begin
        word  = {i_imm[31:12], i_rd, i_opcode};
        legal = (i_opcode inside {OPC_LUI, OPC_AUIPC}) && (i_imm[11:0] == '0);
      end
      INST_J: begin
        word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        legal = (i_opcode == OPC_JAL) && sign_fits(i_imm, 21) && !i_imm[0];
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  assign o_ready = ~full;
  assign o_valid = ~empty;
  assign accept  = i_valid & o_ready & clk_en;
  assign push    = accept & legal;
  assign pop     = o_valid & i_ready & clk_en;
  assign error_d = accept & ~legal;
  assign o_error = error_q;

  // The pulse persists across stalled cycles and clears on the next enabled edge.
  always_ff @(posedge clk) begin
    if (!rst)        error_q <= 1'b0;
    else if (clk_en) error_q <= error_d;
  end

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .push_i     (push),
    .push_data_i(word),
    .pop_i      (pop),
    .head_o     (o_instruction),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (o_count)
  );

endmodule

// File: doc/encode.md
ENCODE -- requirements
Module: encode

Interface
REQ-001 Parameter DEPTH, default 4: output queue depth in instruction words; power of two, at least 2.
REQ-002 clk  input  1: single clock, rising edge.
REQ-003 rst  input  1: reset, synchronous, active-low.
REQ-004 clk_en  input  1: when low, all state holds.
REQ-005 i_valid  input  1: field bundle present.
REQ-006 o_ready  output  1: encoder can accept a field bundle.
REQ-007 i_type  input  3: inst_type_e (ERROR, R, I, S, B, U, J).
REQ-008 i_opcode  input  7; i_funct7  input  7; i_funct3  input  3: opcode and function fields.
REQ-009 i_rs1, i_rs2, i_rd  input  5 each: register indices.
REQ-010 i_imm  input  32: immediate, two's-complement.
REQ-011 o_instruction  output  32: encoded RV32I word.
REQ-012 o_valid  output  1: o_instruction valid.
REQ-013 i_ready  input  1: consumer accepts the word.
REQ-014 o_error  output  1: one-cycle pulse when an accepted bundle is rejected as illegal.
REQ-015 o_count  output  $clog2(DEPTH)+1: number of queued words.

Function
REQ-016 Accept = i_valid & o_ready & clk_en; pop = o_valid & i_ready & clk_en.
REQ-017 o_ready = (o_count < DEPTH); full-queue push is blocked even if a pop occurs in the same cycle (no bypass).
REQ-018 Encoding by type; fields not listed are zero. R: {funct7, rs2, rs1, funct3, rd, opcode}. I: {imm[11:0], rs1, funct3, rd, opcode}. S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}. B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}. U: {imm[31:12], rd, opcode}. J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-019 Legality checks: i_type != ERROR. opcode is in the type's table: R=0110011; I=0010011, 0000011, 1100111, 1110011; S=0100011; B=1100011; U=0110111, 0010111; J=1101111.
REQ-020 Immediate range checks: I/S imm sign-fits 12 bits; B sign-fits 13 bits with imm[0]=0; J sign-fits 21 bits with imm[0]=0; U imm[11:0]=0; R ignores imm.
REQ-021 An accepted illegal bundle is not enqueued; o_error is high for exactly the next clk_en cycle.
REQ-022 Latency: a legal bundle accepted at edge N appears at the queue head. If the queue is empty, o_valid rises after edge N.
REQ-023 Queue order is FIFO. Simultaneous push and pop leaves o_count unchanged. Pointers wrap modulo DEPTH.
REQ-024 While o_valid=1 and i_ready=0, o_instruction is held stable.
REQ-025 o_valid = (o_count != 0); o_instruction is 0 when the queue is empty.

Reset
REQ-026 With rst=0 at an edge, regardless of clk_en: pointers reset, o_count=0, o_valid=0, o_instruction=0, o_error=0, and o_ready=1 in the following cycle.
REQ-027 Reset mid-operation discards all queued words; no partial word is emitted afterwards.

Structure
REQ-028 inst_type_e and the opcode constants belong in a shared package, rv32i_pkg, imported by both decode and encode.
REQ-029 The queue is a sub-module, sync_fifo (parameters WIDTH, DEPTH), with the same clk/clk_en/rst semantics.
REQ-030 Encoding and legality checking are combinational ahead of the fifo push.

Verification
REQ-031 I-type, opcode 0010011, rd=1, rs1=0, funct3=0, imm=5 -> o_instruction 0x00500093 one cycle later, o_error=0.
REQ-032 S-type, opcode 0100011, funct3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423; B-type, opcode 1100011, rs1=rs2=0, funct3=0, imm=-4 -> 0xFE000EE3.
REQ-033 U-type, opcode 0110111, rd=5, imm=0x12345000 -> 0x123452B7. Same bundle with imm=0x12345001 -> o_error pulse, o_count unchanged.
REQ-034 J-type, opcode 1101111, imm=3 -> o_error pulse, no enqueue. Also I-type with opcode 0110011 -> o_error pulse.
REQ-035 DEPTH=4, i_ready=0, push 5 legal words -> o_ready=0 after the 4th, o_count=4, 5th not accepted. Then i_ready=1 -> words drain in order and o_ready returns to 1.
REQ-036 Queue holding 3 words, rst=0 for one edge -> o_count=0, o_valid=0 next cycle. With clk_en=0 during push and pop -> no state change.
